// File: rtl/conv_mac_pipe_if.sv
// conv_mac_pipe_if
// Purpose: bundles the input-beat stream and the output-pixel stream of the
//          convolution MAC engine so both ends share one set of widths.
// Modports:
//   slave  - the engine: consumes beats (in_*), produces results (out_*)
//   master - the producer/consumer around the engine (testbench or datapath)
// Signals:
//   in_valid/in_ready   beat handshake
//   in_pixels/in_kernel TAPS packed signed values, tap i at [i*W +: W], row-major
//   in_last             beat closes the current output pixel
//   in_bias/relu_en     used only on a last beat
//   out_valid/out_ready result handshake
//   out_data/out_sat    post-processed result and its saturation flag
interface conv_mac_pipe_if #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int KSIZE        = 3,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 16
);
  localparam int TAPS = KSIZE * KSIZE;

  logic                          in_valid;
  logic                          in_ready;
  logic [TAPS*PIXEL_WIDTH-1:0]   in_pixels;
  logic [TAPS*KERNEL_WIDTH-1:0]  in_kernel;
  logic                          in_last;
  logic signed [ACC_WIDTH-1:0]   in_bias;
  logic                          relu_en;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   out_data;
  logic                          out_sat;

  modport slave (
    input  in_valid, in_pixels, in_kernel, in_last, in_bias, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_pixels, in_kernel, in_last, in_bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe
// Purpose: pipelined KSIZE x KSIZE convolution multiply-accumulate engine.
//          S1 registers the TAPS signed products, S2 registers their sum,
//          S3 accumulates across input channels and, on the last beat, adds
//          the bias, rounds, shifts, saturates, optionally applies ReLU and
//          loads the output register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - conv_mac_pipe_if.slave: input beat stream and output pixel stream
module conv_mac_pipe #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int KSIZE        = 3,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int TAPS = KSIZE * KSIZE;
  localparam int PW   = PIXEL_WIDTH + KERNEL_WIDTH;
  // One extra bit so the rounding increment can never wrap the result
  localparam int RW   = ACC_WIDTH + 1;
  localparam int SH1  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] ROUND_INC = (SHIFT > 0) ? (RW'(1) << SH1) : '0;
  localparam logic signed [RW-1:0] OUT_MAX   = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN   = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic en;

  logic signed [PW-1:0]        prod_d [TAPS];
  logic signed [PW-1:0]        prod_q [TAPS];
  logic                        s1_valid_d, s1_valid_q;
  logic                        s1_last_d, s1_last_q;
  logic                        s1_relu_d, s1_relu_q;
  logic signed [ACC_WIDTH-1:0] s1_bias_d, s1_bias_q;

  logic signed [ACC_WIDTH-1:0] tree_sum;
  logic signed [ACC_WIDTH-1:0] sum_d, sum_q;
  logic                        s2_valid_d, s2_valid_q;
  logic                        s2_last_d, s2_last_q;
  logic                        s2_relu_d, s2_relu_q;
  logic signed [ACC_WIDTH-1:0] s2_bias_d, s2_bias_q;

  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] t_sum;
  logic signed [RW-1:0]        t_ext;
  logic signed [RW-1:0]        r_val;
  logic [OUT_WIDTH-1:0]        clip_val;
  logic [OUT_WIDTH-1:0]        post_data;
  logic                        post_sat;

  logic                        out_valid_d, out_valid_q;
  logic [OUT_WIDTH-1:0]        out_data_d, out_data_q;
  logic                        out_sat_d, out_sat_q;

  // The whole pipe advances together; it freezes only while a result waits
  // for a downstream that is not ready.
  always_comb begin
    en = !(out_valid_q && !bus.out_ready);
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // S1: one signed product per tap, with the beat's sideband carried along.
  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_relu_d  = s1_relu_q;
    s1_bias_d  = s1_bias_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      s1_last_d  = bus.in_last;
      s1_relu_d  = bus.relu_en;
      s1_bias_d  = bus.in_bias;
      for (int i = 0; i < TAPS; i++) begin
        prod_d[i] = PW'($signed(bus.in_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH])) *
                    PW'($signed(bus.in_kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH]));
      end
    end
  end

  // S2: sign-extend every product to accumulator width and sum them.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      tree_sum = tree_sum + ACC_WIDTH'(prod_q[i]);
    end
    sum_d      = sum_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_relu_d  = s2_relu_q;
    s2_bias_d  = s2_bias_q;
    if (en) begin
      sum_d      = tree_sum;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_relu_d  = s1_relu_q;
      s2_bias_d  = s1_bias_q;
    end
  end

  // Post-processing of the channel-complete total: round half toward +inf,
  // arithmetic shift, clip to the output range, then ReLU on the clipped
  // value. ReLU never clears the saturation flag.
  always_comb begin
    t_sum = acc_q + sum_q + s2_bias_q;
    t_ext = RW'(t_sum);
    if (SHIFT > 0) begin
      r_val = (t_ext + ROUND_INC) >>> SHIFT;
    end else begin
      r_val = t_ext;
    end
    post_sat = 1'b0;
    clip_val = r_val[OUT_WIDTH-1:0];
    if (r_val > OUT_MAX) begin
      clip_val = OUT_MAX[OUT_WIDTH-1:0];
      post_sat = 1'b1;
    end else if (r_val < OUT_MIN) begin
      clip_val = OUT_MIN[OUT_WIDTH-1:0];
      post_sat = 1'b1;
    end
    post_data = clip_val;
    if (s2_relu_q && clip_val[OUT_WIDTH-1]) begin
      post_data = '0;
    end
  end

  // S3: accumulate non-last beats; a last beat emits a result and restarts
  // the accumulator. Whenever the pipe advances the old result is either
  // consumed or absent, so out_valid simply follows whether a new one lands.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = post_data;
          out_sat_d   = post_sat;
        end else begin
          acc_d = acc_q + sum_q;
        end
      end
    end
  end

  // State registers; reset discards partial sums and every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_bias_q   <= '0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      s2_bias_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_relu_q   <= s1_relu_d;
      s1_bias_q   <= s1_bias_d;
      sum_q       <= sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_relu_q   <= s2_relu_d;
      s2_bias_q   <= s2_bias_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
endmodule
